fifo_rd_ptr_ctrl: RTL and testbench

- Read-side pointer controller of the async FIFO. Runs entirely in the destination (read) clock domain.
- Consumes the write pointer after it has been Gray-coded and double-flop synchronized into this domain.
- Maintains the binary and Gray read pointers, generates memory read enable/address, registered empty flag, fill level and read-data valid.
- Exports the registered Gray read pointer for synchronization back into the write domain.

---
 rtl/fifo_pkg.sv | 38 +++
 rtl/fifo_rd_ptr_ctrl_if.sv | 71 +++++++
 rtl/gray_ptr_counter.sv | 55 +++++
 rtl/fifo_rd_ptr_ctrl.sv | 126 ++++++++++++
 tb/tb_fifo_rd_ptr_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared types and pointer-code helpers for the async FIFO pointer
// controllers (read side and write side).
//
// Contents:
//   DEFAULT_SIZE  default pointer width in bits, including the wrap bit
//   PTR_W_MAX     width of the helper-function argument; callers zero-extend
//                 their pointers into it and cast the result back down
//   ptr_t/addr_t  pointer and memory-address types for the default width
//   bin2gray      binary -> reflected Gray code
//   gray2bin      Gray -> binary, MSB-down XOR chain
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_SIZE = 4;
    localparam int PTR_W_MAX    = 32;

    typedef logic [DEFAULT_SIZE-1:0] ptr_t;
    typedef logic [DEFAULT_SIZE-2:0] addr_t;
    typedef logic [PTR_W_MAX-1:0]    ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero bits above the real pointer width leave the decode unaffected,
    // so one function serves every pointer width up to PTR_W_MAX.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_rd_ptr_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_ptr_ctrl_if
// Signal bundle between the read-pointer controller and its environment
// (write-pointer synchronizer, consumer, FIFO memory).
//
// Signals:
//   wr_ptr_gray_sync  Gray write pointer, already synchronized to dest_clk
//   rd_req            consumer requests one word
//   mem_rd_en         memory read strobe (combinational accept)
//   mem_rd_addr       memory read address
//   rd_ptr_gray       registered Gray read pointer toward the write domain
//   empty             registered empty flag
//   fill_level        registered word count
//   rd_valid          memory read data valid
//   almost_empty      (FIFO_RD_ALMOST_EMPTY_EN only) fill at/below threshold
//   ptr_err           (FIFO_RD_ALMOST_EMPTY_EN only) sticky pointer error
//
// Modports:
//   slave   the controller
//   master  the environment driving requests and the write pointer
// ---------------------------------------------------------------------------
interface fifo_rd_ptr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
);

    logic [SIZE-1:0] wr_ptr_gray_sync;
    logic            rd_req;
    logic            mem_rd_en;
    logic [SIZE-2:0] mem_rd_addr;
    logic [SIZE-1:0] rd_ptr_gray;
    logic            empty;
    logic [SIZE-1:0] fill_level;
    logic            rd_valid;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    logic            almost_empty;
    logic            ptr_err;
`endif

    modport slave (
        input  wr_ptr_gray_sync,
        input  rd_req,
        output mem_rd_en,
        output mem_rd_addr,
        output rd_ptr_gray,
        output empty,
        output fill_level,
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        output almost_empty,
        output ptr_err,
`endif
        output rd_valid
    );

    modport master (
        output wr_ptr_gray_sync,
        output rd_req,
        input  mem_rd_en,
        input  mem_rd_addr,
        input  rd_ptr_gray,
        input  empty,
        input  fill_level,
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        input  almost_empty,
        input  ptr_err,
`endif
        input  rd_valid
    );

endinterface : fifo_rd_ptr_ctrl_if

// File: rtl/gray_ptr_counter.sv
// ---------------------------------------------------------------------------
// gray_ptr_counter
// Binary + Gray pointer register pair, advanced by one on inc. Shared by
// the read-side and write-side FIFO pointer controllers.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (both pointers to 0)
//   inc        advance the pointer by one this cycle
//   bin_next   combinational next binary pointer
//   gray_next  combinational next Gray pointer
//   bin        registered binary pointer
//   gray       registered Gray pointer
// ---------------------------------------------------------------------------
module gray_ptr_counter
    import fifo_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [SIZE-1:0] bin_next,
    output logic [SIZE-1:0] gray_next,
    output logic [SIZE-1:0] bin,
    output logic [SIZE-1:0] gray
);

    logic [SIZE-1:0] bin_d;
    logic [SIZE-1:0] gray_d;
    logic [SIZE-1:0] bin_q;
    logic [SIZE-1:0] gray_q;

    // Wrap from all-ones to zero falls out of the modulo-2^SIZE add.
    always_comb begin
        bin_d  = bin_q + SIZE'(inc);
        gray_d = SIZE'(bin2gray(PTR_W_MAX'(bin_d)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin_next  = bin_d;
    assign gray_next = gray_d;
    assign bin       = bin_q;
    assign gray      = gray_q;

endmodule : gray_ptr_counter

// File: rtl/fifo_rd_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ptr_ctrl
// Read-side pointer controller of the async FIFO, entirely in dest_clk.
// Accepts consumer reads while not empty, drives the memory read strobe
// and address, keeps the binary/Gray read pointers and produces the
// registered empty flag, fill level and read-data valid.
//
// Ports:
//   dest_clk  read-domain clock, rising edge
//   rst       synchronous active-high reset
//   bus       fifo_rd_ptr_ctrl_if.slave (see interface header)
//
// Parameters:
//   SIZE       pointer width incl. wrap bit; depth = 2^(SIZE-1)
//   AE_THRESH  almost-empty threshold in words (optional feature only)
//
// Build option:
//   FIFO_RD_ALMOST_EMPTY_EN  adds almost_empty and sticky ptr_err outputs.
// ---------------------------------------------------------------------------
module fifo_rd_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int SIZE      = DEFAULT_SIZE
`ifdef FIFO_RD_ALMOST_EMPTY_EN
   ,parameter int AE_THRESH = 2
`endif
) (
    input  logic                  dest_clk,
    input  logic                  rst,
    fifo_rd_ptr_ctrl_if.slave     bus
);

    logic            accept;
    logic [SIZE-1:0] rd_bin_next;
    logic [SIZE-1:0] rd_gray_next;
    logic [SIZE-1:0] rd_bin;
    logic [SIZE-1:0] rd_gray;
    logic [SIZE-1:0] wr_ptr_bin;
    logic [SIZE-1:0] ptr_diff;

    logic            empty_d;
    logic            empty_q;
    logic [SIZE-1:0] fill_level_d;
    logic [SIZE-1:0] fill_level_q;
    logic            rd_valid_d;
    logic            rd_valid_q;

    // The pointer MSB only matters for the wrap compare, not the address.
    logic            unused_rd_bin_msb;

    // Once reset completes empty_q is 1, so the strobe is 0 out of reset.
    assign accept = bus.rd_req & ~empty_q;

    gray_ptr_counter #(
        .SIZE      (SIZE)
    ) u_rd_ptr (
        .clk       (dest_clk),
        .rst       (rst),
        .inc       (accept),
        .bin_next  (rd_bin_next),
        .gray_next (rd_gray_next),
        .bin       (rd_bin),
        .gray      (rd_gray)
    );

    always_comb begin
        wr_ptr_bin   = SIZE'(gray2bin(PTR_W_MAX'(bus.wr_ptr_gray_sync)));
        ptr_diff     = wr_ptr_bin - rd_bin_next;
        // Empty uses the raw Gray compare so no decode sits in the flag path.
        empty_d      = (rd_gray_next == bus.wr_ptr_gray_sync);
        fill_level_d = ptr_diff;
        rd_valid_d   = accept;
    end

    always_ff @(posedge dest_clk) begin
        if (rst) begin
            empty_q      <= 1'b1;
            fill_level_q <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            empty_q      <= empty_d;
            fill_level_q <= fill_level_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    localparam logic [SIZE-1:0] AE_LIMIT = SIZE'(AE_THRESH);
    localparam logic [SIZE-1:0] DEPTH    = SIZE'(2 ** (SIZE - 1));

    logic almost_empty_d;
    logic almost_empty_q;
    logic ptr_err_d;
    logic ptr_err_q;

    // A difference beyond the depth means the write pointer ran ahead by
    // more than the FIFO holds; it is flagged, never corrected.
    always_comb begin
        almost_empty_d = (ptr_diff <= AE_LIMIT);
        ptr_err_d      = ptr_err_q | (ptr_diff > DEPTH);
    end

    always_ff @(posedge dest_clk) begin
        if (rst) begin
            almost_empty_q <= 1'b1;
            ptr_err_q      <= 1'b0;
        end else begin
            almost_empty_q <= almost_empty_d;
            ptr_err_q      <= ptr_err_d;
        end
    end

    assign bus.almost_empty = almost_empty_q;
    assign bus.ptr_err      = ptr_err_q;
`endif

    assign unused_rd_bin_msb = rd_bin[SIZE-1];

    assign bus.mem_rd_en   = accept;
    assign bus.mem_rd_addr = rd_bin[SIZE-2:0];
    assign bus.rd_ptr_gray = rd_gray;
    assign bus.empty       = empty_q;
    assign bus.fill_level  = fill_level_q;
    assign bus.rd_valid    = rd_valid_q;

endmodule : fifo_rd_ptr_ctrl

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_ptr_ctrl
// Self-checking bench for fifo_rd_ptr_ctrl (SIZE=4). A word-count model
// (read count, write count, fill = difference mod 16) predicts every output.
// Optional outputs are checked when FIFO_RD_ALMOST_EMPTY_EN is defined.
// ---------------------------------------------------------------------------
module tb_fifo_rd_ptr_ctrl;
    import fifo_pkg::*;

    localparam int SZ = 4;
    localparam int AE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_ptr_ctrl_if #(.SIZE(SZ)) bus();

    fifo_rd_ptr_ctrl #(
        .SIZE      (SZ)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
       ,.AE_THRESH (AE)
`endif
    ) dut (
        .dest_clk  (clk),
        .rst       (rst),
        .bus       (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: plain counts modulo 16.
    int m_rd    = 0;
    int m_fill  = 0;
    int wb      = 0;
    bit m_empty = 1'b1;
    bit m_valid = 1'b0;
    bit m_ae    = 1'b1;
    bit m_err   = 1'b0;
    bit exp_acc;
    int exp_addr_pre;
    logic       obs_rd_en;
    logic [2:0] obs_addr;

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    // One dest_clk cycle: drive inputs, sample the combinational strobe just
    // before the edge, advance the model, return 1 time unit after the edge.
    task automatic cycle(input bit rq, input int w, input bit r);
        bus.rd_req           = rq;
        bus.wr_ptr_gray_sync = to_gray(w);
        rst                  = r;
        wb                   = w % 16;
        #3;
        obs_rd_en    = bus.mem_rd_en;
        obs_addr     = bus.mem_rd_addr;
        exp_acc      = rq && !m_empty;
        exp_addr_pre = m_rd % 8;
        @(posedge clk);
        if (r) begin
            m_rd = 0; m_fill = 0; m_empty = 1'b1; m_valid = 1'b0;
            m_ae = 1'b1; m_err = 1'b0;
        end else begin
            m_rd    = (m_rd + (exp_acc ? 1 : 0)) % 16;
            m_fill  = (wb + 16 - m_rd) % 16;
            m_empty = (m_fill == 0);
            m_valid = exp_acc;
            m_ae    = (m_fill <= AE);
            m_err   = m_err || (m_fill > 8);
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 0, 1'b1);
        cycle(1'b1, 0, 1'b1);
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        n_tests++; if (bus.fill_level !== 4'd0) begin n_fail++; $display("FAIL reset_fill got %0d want 0", bus.fill_level); end
        n_tests++; if (bus.rd_ptr_gray !== 4'b0000) begin n_fail++; $display("FAIL reset_gray got %b want 0000", bus.rd_ptr_gray); end
        n_tests++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.rd_valid); end
        n_tests++; if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", bus.mem_rd_en); end
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        n_tests++; if (bus.almost_empty !== 1'b1 || bus.ptr_err !== 1'b0) begin n_fail++; $display("FAIL reset_ae_err got ae=%b err=%b want ae=1 err=0", bus.almost_empty, bus.ptr_err); end
`endif
    endtask

    task automatic test_drain_two();
        cycle(1'b1, 2, 1'b0);
        n_tests++; if (bus.empty !== 1'b0 || bus.fill_level !== 4'd2) begin n_fail++; $display("FAIL drain_fill got empty=%b fill=%0d want empty=0 fill=2", bus.empty, bus.fill_level); end
        cycle(1'b1, 2, 1'b0);
        n_tests++; if (obs_rd_en !== 1'b1 || obs_addr !== 3'd0) begin n_fail++; $display("FAIL drain_acc0 got en=%b addr=%0d want en=1 addr=0", obs_rd_en, obs_addr); end
        n_tests++; if (bus.rd_valid !== 1'b1 || bus.fill_level !== 4'd1) begin n_fail++; $display("FAIL drain_mid got valid=%b fill=%0d want valid=1 fill=1", bus.rd_valid, bus.fill_level); end
        cycle(1'b1, 2, 1'b0);
        n_tests++; if (obs_rd_en !== 1'b1 || obs_addr !== 3'd1) begin n_fail++; $display("FAIL drain_acc1 got en=%b addr=%0d want en=1 addr=1", obs_rd_en, obs_addr); end
        n_tests++; if (bus.empty !== 1'b1 || bus.fill_level !== 4'd0 || bus.rd_ptr_gray !== 4'b0011 || bus.rd_valid !== 1'b1)
            begin n_fail++; $display("FAIL drain_end got empty=%b fill=%0d gray=%b valid=%b want 1 0 0011 1", bus.empty, bus.fill_level, bus.rd_ptr_gray, bus.rd_valid); end
    endtask

    task automatic test_read_empty();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2, 1'b0);
            n_tests++; if (obs_rd_en !== 1'b0 || bus.rd_ptr_gray !== 4'b0011 || bus.rd_valid !== 1'b0 || bus.empty !== 1'b1)
                begin n_fail++; $display("FAIL empty_read[%0d] got en=%b gray=%b valid=%b empty=%b want 0 0011 0 1", i, obs_rd_en, bus.rd_ptr_gray, bus.rd_valid, bus.empty); end
        end
    endtask

    // Write pointer kept 5 ahead of the current read count, so the steady
    // fill after each accept is 4 while the read pointer runs past 7 and 15.
    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, m_rd + 5, 1'b0);
            n_tests++; if (bus.rd_ptr_gray !== to_gray(m_rd) || bus.fill_level !== 4'(m_fill) || bus.mem_rd_addr !== 3'(m_rd % 8))
                begin n_fail++; $display("FAIL wrap[%0d] got gray=%b fill=%0d addr=%0d want gray=%b fill=%0d addr=%0d", i, bus.rd_ptr_gray, bus.fill_level, bus.mem_rd_addr, to_gray(m_rd), m_fill, m_rd % 8); end
            if (m_rd == 8) begin
                n_tests++; if (bus.rd_ptr_gray !== 4'b1100 || bus.mem_rd_addr !== 3'd0) begin n_fail++; $display("FAIL wrap_8 got gray=%b addr=%0d want 1100 0", bus.rd_ptr_gray, bus.mem_rd_addr); end
            end
            if (m_rd == 14) begin
                n_tests++; if (bus.fill_level !== 4'd4) begin n_fail++; $display("FAIL wrap_14 got fill=%0d want 4", bus.fill_level); end
            end
            if (m_rd == 0) begin
                n_tests++; if (bus.rd_ptr_gray !== 4'b0000) begin n_fail++; $display("FAIL wrap_0 got gray=%b want 0000", bus.rd_ptr_gray); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        cycle(1'b0, m_rd + 3, 1'b0);
        n_tests++; if (bus.fill_level !== 4'd3) begin n_fail++; $display("FAIL rstmid_fill got %0d want 3", bus.fill_level); end
        cycle(1'b1, wb, 1'b1);
        n_tests++; if (obs_rd_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_en got %b want 1", obs_rd_en); end
        n_tests++; if (bus.rd_ptr_gray !== 4'b0000 || bus.empty !== 1'b1 || bus.rd_valid !== 1'b0)
            begin n_fail++; $display("FAIL rstmid got gray=%b empty=%b valid=%b want 0000 1 0", bus.rd_ptr_gray, bus.empty, bus.rd_valid); end
        cycle(1'b0, 0, 1'b0);
    endtask

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    task automatic test_almost_empty();
        cycle(1'b0, 3, 1'b0);
        n_tests++; if (bus.fill_level !== 4'd3 || bus.almost_empty !== 1'b0) begin n_fail++; $display("FAIL ae_3 got fill=%0d ae=%b want 3 0", bus.fill_level, bus.almost_empty); end
        cycle(1'b1, 3, 1'b0);
        n_tests++; if (bus.fill_level !== 4'd2 || bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL ae_2 got fill=%0d ae=%b want 2 1", bus.fill_level, bus.almost_empty); end
        cycle(1'b0, m_rd + 9, 1'b0);
        n_tests++; if (bus.ptr_err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", bus.ptr_err); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, m_rd + 1, 1'b0);
            n_tests++; if (bus.ptr_err !== 1'b1) begin n_fail++; $display("FAIL err_hold[%0d] got %b want 1", i, bus.ptr_err); end
        end
        cycle(1'b0, 0, 1'b1);
        n_tests++; if (bus.ptr_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", bus.ptr_err); end
        cycle(1'b0, 0, 1'b0);
    endtask
`endif

    // Random requests, legal write-pointer jumps of 0..3 and rare resets.
    task automatic test_random();
        int w;
        for (int i = 0; i < 400; i++) begin
            w = wb + int'($urandom_range(0, 3));
            if (((w + 16 - m_rd) % 16) > 8) w = wb;
            if ($urandom_range(0, 63) == 0) cycle(1'($urandom_range(0, 1)), 0, 1'b1);
            else                            cycle(1'($urandom_range(0, 1)), w, 1'b0);
            n_tests++;
            if (obs_rd_en !== exp_acc || obs_addr !== 3'(exp_addr_pre) || bus.rd_ptr_gray !== to_gray(m_rd) ||
                bus.empty !== m_empty || bus.fill_level !== 4'(m_fill) || bus.rd_valid !== m_valid)
            begin
                n_fail++;
                $display("FAIL rand[%0d] got en=%b addr=%0d gray=%b empty=%b fill=%0d valid=%b want en=%b addr=%0d gray=%b empty=%b fill=%0d valid=%b",
                         i, obs_rd_en, obs_addr, bus.rd_ptr_gray, bus.empty, bus.fill_level, bus.rd_valid,
                         exp_acc, exp_addr_pre, to_gray(m_rd), m_empty, m_fill, m_valid);
            end
`ifdef FIFO_RD_ALMOST_EMPTY_EN
            n_tests++;
            if (bus.almost_empty !== m_ae || bus.ptr_err !== m_err) begin
                n_fail++;
                $display("FAIL rand_ae[%0d] got ae=%b err=%b want ae=%b err=%b", i, bus.almost_empty, bus.ptr_err, m_ae, m_err);
            end
`endif
        end
    endtask

    initial begin
        bus.rd_req           = 1'b1;
        bus.wr_ptr_gray_sync = '0;
        test_reset();
        test_drain_two();
        test_read_empty();
        test_wrap();
        test_reset_mid_read();
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        test_almost_empty();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout after 200000 time units");
        $fatal(1, "timeout");
    end

endmodule : tb_fifo_rd_ptr_ctrl
